// File: rtl/mux2to1_beh.sv
// mux2to1_beh: width-parameterised 2:1 multiplexer with an optional output
// register, a validity flag and a record of the select that produced `out`.
module mux2to1_beh #(
  parameter int unsigned WIDTH   = 4,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             sel_q
);

  logic [WIDTH-1:0] sel_val;
  logic             sel_bit;

  // Select b only on a definite 1; an unknown select falls through to a.
  always_comb begin
    sel_val = a;
    sel_bit = 1'b0;
    if (s == 1'b1) begin
      sel_val = b;
      sel_bit = 1'b1;
    end
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] out_q, out_d;
    logic             sel_hold_q, sel_hold_d;
    logic             valid_q, valid_d;

    // Next state: load the selection when enabled, otherwise hold.
    always_comb begin
      out_d      = out_q;
      sel_hold_d = sel_hold_q;
      valid_d    = valid_q;
      if (en) begin
        out_d      = sel_val;
        sel_hold_d = sel_bit;
        valid_d    = 1'b1;
      end
    end

    // Output register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q      <= '0;
        sel_hold_q <= 1'b0;
        valid_q    <= 1'b0;
      end else begin
        out_q      <= out_d;
        sel_hold_q <= sel_hold_d;
        valid_q    <= valid_d;
      end
    end

    assign out       = out_q;
    assign sel_q     = sel_hold_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    logic valid_q, valid_d;

    // Validity sets on the first edge out of reset; en plays no part here.
    always_comb begin
      valid_d = 1'b1;
    end

    // Validity flag register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    assign out       = sel_val;
    assign sel_q     = sel_bit;
    assign out_valid = valid_q;
  end

endmodule

// File: tb/tb_mux2to1_beh.sv
// Directed self-checking bench: a registered 4-bit instance and a
// combinational 8-bit instance sharing clock, reset, enable and select.
module tb_mux2to1_beh;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       s;
  logic [3:0] a, b;
  logic [7:0] a8, b8;

  logic [3:0] out;
  logic       out_valid, sel_q;
  logic [7:0] out_c;
  logic       out_valid_c, sel_q_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux2to1_beh #(.WIDTH(4), .REG_OUT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .s(s),
    .out(out), .out_valid(out_valid), .sel_q(sel_q)
  );

  mux2to1_beh #(.WIDTH(8), .REG_OUT(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a8), .b(b8), .s(s),
    .out(out_c), .out_valid(out_valid_c), .sel_q(sel_q_c)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] eo, input logic ev, input logic es);
    chk({tag, ".out"}, {4'h0, out}, {4'h0, eo});
    chk({tag, ".valid"}, {7'h0, out_valid}, {7'h0, ev});
    chk({tag, ".sel_q"}, {7'h0, sel_q}, {7'h0, es});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; s = 1'b1; a = 4'h3; b = 4'hC;
    a8 = 8'h00; b8 = 8'h00;
    #1;
    chk_reg("rst_async", 4'h0, 1'b0, 1'b0);
    chk("rst_c_valid", {7'h0, out_valid_c}, 8'h00);

    // Reset held through edges with en=1 and toggling inputs.
    for (int i = 0; i < 3; i++) begin
      s = ~s; a = ~a; b = b + 4'h1;
      tick();
      chk_reg("rst_hold", 4'h0, 1'b0, 1'b0);
    end
    chk("rst_hold_c_valid", {7'h0, out_valid_c}, 8'h00);

    // Release reset; first edge loads a.
    a = 4'b0101; b = 4'b1010; s = 1'b0; rst_n = 1'b1;
    #1;
    chk_reg("release_pre_edge", 4'h0, 1'b0, 1'b0);
    tick();
    chk_reg("release_load", 4'h5, 1'b1, 1'b0);
    chk("release_c_valid", {7'h0, out_valid_c}, 8'h01);

    // Select sweep 0,0,1,0.
    s = 1'b0; tick(); chk_reg("sweep0", 4'h5, 1'b1, 1'b0);
    s = 1'b1; #1;     chk_reg("sweep_between", 4'h5, 1'b1, 1'b0);
    tick();           chk_reg("sweep1", 4'hA, 1'b1, 1'b1);
    s = 1'b0; tick(); chk_reg("sweep2", 4'h5, 1'b1, 1'b0);

    // Operands change together with the select.
    s = 1'b1; a = 4'hF; b = 4'hE; tick(); chk_reg("opchg_b", 4'hE, 1'b1, 1'b1);
    s = 1'b0; tick();                     chk_reg("opchg_a", 4'hF, 1'b1, 1'b0);

    // Hold with en=0.
    s = 1'b1; a = 4'h5; b = 4'hA; tick(); chk_reg("hold_load", 4'hA, 1'b1, 1'b1);
    en = 1'b0; s = 1'b0; a = 4'h3; b = 4'h6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reg("hold", 4'hA, 1'b1, 1'b1);
      a = a + 4'h1;
    end
    en = 1'b1; tick(); chk_reg("hold_resume", 4'h6, 1'b1, 1'b0);

    // Asynchronous reset pulse between edges.
    s = 1'b1; b = 4'hA; tick(); chk_reg("areset_pre", 4'hA, 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_reg("areset_now", 4'h0, 1'b0, 1'b0);
    chk("areset_c_valid", {7'h0, out_valid_c}, 8'h00);
    #1 rst_n = 1'b1;
    tick(); chk_reg("areset_resume", 4'hA, 1'b1, 1'b1);
    chk("areset_c_valid_back", {7'h0, out_valid_c}, 8'h01);

    // Combinational instance follows the select with no edge.
    a8 = 8'hA5; b8 = 8'h3C;
    s = 1'b0; #1; chk("comb_s0", out_c, 8'hA5); chk("comb_selq0", {7'h0, sel_q_c}, 8'h00);
    s = 1'b1; #1; chk("comb_s1", out_c, 8'h3C); chk("comb_selq1", {7'h0, sel_q_c}, 8'h01);
    s = 1'b0; #1; chk("comb_s0b", out_c, 8'hA5);
    en = 1'b0; b8 = 8'h77; s = 1'b1; #1; chk("comb_en_ignored", out_c, 8'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux2to1_beh.md
# mux2to1_beh

Registered, width-parameterised 2:1 multiplexer. Selects operand `a` when `s`=0 and operand `b` when `s`=1, and drives the result from an output register in the single system clock domain. It is a datapath selection primitive placed between operand sources and a downstream consumer that needs a glitch-free, registered result with a validity flag.

## Interface
Parameters:
- `WIDTH`, 4: bit width of `a`, `b` and `out`; legal range 1..64.
- `REG_OUT`, 1: 1 selects a registered output with one cycle of latency; 0 selects a combinational output.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous and active-low.
- `en`  input  1  load enable for the output register.
- `a`  input  WIDTH  operand selected when `s`=0.
- `b`  input  WIDTH  operand selected when `s`=1.
- `s`  input  1  select.
- `out`  output  WIDTH  selected operand.
- `out_valid`  output  1  `out` holds a selected value, not the reset value.
- `sel_q`  output  1  value of `s` that produced the current `out`.

## Operation
- Selection function: `sel_val` = `b` if `s`=1, else `a`. The selection is bitwise across all WIDTH bits, with no arithmetic and no width change.
- An X or Z on `s` is not a legal input. The implementation drives `a` in that case, so `s`=X is treated as 0.
- REG_OUT=1:
  - `rst_n`=0 immediately forces `out`=0, `out_valid`=0 and `sel_q`=0. This happens without a clock edge.
  - On a rising edge with `rst_n`=1 and `en`=1: `out`<=`sel_val`, `sel_q`<=`s`, `out_valid`<=1.
  - On a rising edge with `en`=0: all outputs hold.
  - Changes to `a`, `b` or `s` between edges have no effect on outputs.
- REG_OUT=0:
  - `out` = `sel_val` continuously, and `sel_q` = `s` continuously.
  - `out_valid` is a register: it clears asynchronously on `rst_n`=0 and sets on the first rising edge with `rst_n`=1.
  - `en` is ignored.
- Reset asserted mid-operation overrides any load on the same edge. Outputs stay at their reset values while `rst_n`=0.
- Reset deassertion takes effect at the next rising edge. `en`=1 on the first edge after deassertion loads normally.

## Timing
- REG_OUT=1: latency of 1 clock from `a`/`b`/`s` sampled at edge N to `out` valid after edge N. Throughput is one new selection per clock.
- REG_OUT=0: combinational, with zero-cycle latency from `a`, `b` and `s` to `out`.
- No handshake exists. `en` is the only flow control and has no backpressure.
- When `s` and the operands change on the same edge, the edge samples their pre-edge values. The usual setup and hold rules apply.

## Test plan
- Reset: hold `rst_n`=0 with `en`=1 and toggling inputs. Required: `out`=0, `out_valid`=0, `sel_q`=0. Then release reset with `a`=4'b0101, `b`=4'b1010, `s`=0. Required: after the first edge, `out`=5, `out_valid`=1.
- Select sweep with `a`=0101 and `b`=1010 (`en`=1):
  - `s`=0, then `s`=0, then `s`=1, then `s`=0, each held one clock.
  - Required: `out` sequence 5, 5, 10, 5, each appearing one edge after its `s`.
  - `sel_q` tracks `s` with the same one-edge delay.
- Operand change with select: drive `s`=1 together with `a`=1111 and `b`=1110, then `s`=0. Required: `out`=14, then 15.
- Hold: load `out`=10 with `s`=1, then set `en`=0 and apply `s`=0 with new operands for 3 clocks. Required: `out` stays 10 and `sel_q` stays 1. Then set `en`=1. Required: `out`=`a` on the next edge.
- Asynchronous reset mid-stream: with `out`=10, pulse `rst_n` low between clock edges. Required: `out`=0 and `out_valid`=0 immediately, without waiting for an edge, and normal loading resumes after release.
- REG_OUT=0, WIDTH=8:
  - Drive `a`=8'hA5, `b`=8'h3C and toggle `s` between edges. Required: `out` follows immediately (A5 when `s`=0, 3C when `s`=1).
  - Required: `out_valid` rises on the first edge after reset.
